// File: rtl/reorder_buffer_if.sv
// Bundle of the reorder buffer's dispatch, CDB, commit and operand-lookup
// signals.
//   master : the surrounding pipeline, which drives the requests.
//   slave  : the reorder buffer, which drives the status and data.
// Dispatch : WE, inst_opcode, inst_dest, inst_predict -> alloc_addr, full
// CDB      : cdb_valid, cdb_tag, cdb_value
// Commit   : RE -> valid_out, opcode_out, dest_out, value_out, predict_out,
//            rob_addr, empty
// Lookup   : rd_tag_a/b -> rd_valid_a/b, rd_value_a/b
// opcode_width and reg_width are the widths of the LC-3b opcode and
// register fields.
interface reorder_buffer_if #(
  parameter int data_width   = 16,
  parameter int tag_width    = 3,
  parameter int opcode_width = 4,
  parameter int reg_width    = 3
);
  logic                    WE;
  logic [opcode_width-1:0] inst_opcode;
  logic [reg_width-1:0]    inst_dest;
  logic                    inst_predict;
  logic [tag_width-1:0]    alloc_addr;
  logic                    full;

  logic                    cdb_valid;
  logic [tag_width-1:0]    cdb_tag;
  logic [data_width-1:0]   cdb_value;

  logic                    RE;
  logic                    valid_out;
  logic [opcode_width-1:0] opcode_out;
  logic [reg_width-1:0]    dest_out;
  logic [data_width-1:0]   value_out;
  logic                    predict_out;
  logic [tag_width-1:0]    rob_addr;
  logic                    empty;

  logic [tag_width-1:0]    rd_tag_a;
  logic [tag_width-1:0]    rd_tag_b;
  logic                    rd_valid_a;
  logic                    rd_valid_b;
  logic [data_width-1:0]   rd_value_a;
  logic [data_width-1:0]   rd_value_b;

  modport master (
    output WE, inst_opcode, inst_dest, inst_predict,
    output cdb_valid, cdb_tag, cdb_value,
    output RE, rd_tag_a, rd_tag_b,
    input  alloc_addr, full, valid_out, opcode_out, dest_out, value_out,
    input  predict_out, rob_addr, empty,
    input  rd_valid_a, rd_valid_b, rd_value_a, rd_value_b
  );

  modport slave (
    input  WE, inst_opcode, inst_dest, inst_predict,
    input  cdb_valid, cdb_tag, cdb_value,
    input  RE, rd_tag_a, rd_tag_b,
    output alloc_addr, full, valid_out, opcode_out, dest_out, value_out,
    output predict_out, rob_addr, empty,
    output rd_valid_a, rd_valid_b, rd_value_a, rd_value_b
  );
endinterface

// File: rtl/reorder_buffer.sv
// Circular reorder buffer. Dispatch allocates entries at the tail in
// program order. The CDB fills results by tag. Commit retires the head
// entry once its result is ready. Two lookup ports serve renaming, and
// each lookup port forwards the CDB value broadcast in the same cycle.
// Ports:
//   clk   : clock; all state changes on the rising edge.
//   clr   : synchronous active-high reset. It clears all state, including
//           the data fields.
//   flush : mispredict flush. It empties the buffer and overrides all other
//           requests in that cycle. The data fields are kept.
//   bus   : dispatch, CDB, commit and lookup signals (see reorder_buffer_if).
module reorder_buffer #(
  parameter int data_width   = 16,
  parameter int tag_width    = 3,
  parameter int opcode_width = 4,
  parameter int reg_width    = 3
) (
  input  logic            clk,
  input  logic            clr,
  input  logic            flush,
  reorder_buffer_if.slave bus
);
  localparam int depth = 1 << tag_width;

  logic [tag_width-1:0]    head_reg;
  logic [tag_width-1:0]    tail_reg;
  logic [tag_width:0]      count_reg;
  logic [depth-1:0]        alloc_reg;
  logic [depth-1:0]        ready_reg;
  logic [depth-1:0]        predict_reg;
  logic [opcode_width-1:0] opcode_reg [depth];
  logic [reg_width-1:0]    dest_reg   [depth];
  logic [data_width-1:0]   value_reg  [depth];

  logic             full;
  logic             empty;
  logic             head_valid;
  logic             do_alloc;
  logic             do_retire;
  logic [depth-1:0] alloc_hit;
  logic [depth-1:0] cdb_hit;
  logic [depth-1:0] retire_hit;

  // Every decision below uses the state before the clock edge. Because of
  // that, a retire in the same cycle cannot free a slot for a WE that
  // arrives while the buffer is full.
  assign full       = (count_reg == (tag_width + 1)'(depth));
  assign empty      = (count_reg == '0);
  assign head_valid = !empty && ready_reg[head_reg];
  assign do_alloc   = bus.WE && !full;
  assign do_retire  = bus.RE && head_valid;

  genvar gi;
  generate
    for (gi = 0; gi < depth; gi++) begin : g_hit
      assign alloc_hit[gi]  = do_alloc && (tail_reg == tag_width'(gi));
      // A broadcast to an unallocated entry is dropped. So is a broadcast
      // to the entry that is being allocated in this cycle.
      assign cdb_hit[gi]    = bus.cdb_valid && alloc_reg[gi] && !alloc_hit[gi]
                              && (bus.cdb_tag == tag_width'(gi));
      assign retire_hit[gi] = do_retire && (head_reg == tag_width'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (clr || flush) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (do_alloc)  tail_reg <= tail_reg + tag_width'(1);
      if (do_retire) head_reg <= head_reg + tag_width'(1);
      if (do_alloc && !do_retire)
        count_reg <= count_reg + (tag_width + 1)'(1);
      else if (!do_alloc && do_retire)
        count_reg <= count_reg - (tag_width + 1)'(1);
    end
  end

  // An entry is never allocated and retired in the same cycle. Allocating
  // the head entry needs an empty buffer, and retiring needs a non-empty
  // one. If a retire and a CDB write hit the same entry, the retire wins,
  // because the slot is being freed.
  always_ff @(posedge clk) begin
    for (int i = 0; i < depth; i++) begin
      if (clr) begin
        alloc_reg[i]   <= 1'b0;
        ready_reg[i]   <= 1'b0;
        predict_reg[i] <= 1'b0;
        opcode_reg[i]  <= '0;
        dest_reg[i]    <= '0;
        value_reg[i]   <= '0;
      end else if (flush) begin
        alloc_reg[i] <= 1'b0;
        ready_reg[i] <= 1'b0;
      end else if (alloc_hit[i]) begin
        alloc_reg[i]   <= 1'b1;
        ready_reg[i]   <= 1'b0;
        predict_reg[i] <= bus.inst_predict;
        opcode_reg[i]  <= bus.inst_opcode;
        dest_reg[i]    <= bus.inst_dest;
        value_reg[i]   <= '0;
      end else if (retire_hit[i]) begin
        alloc_reg[i] <= 1'b0;
        ready_reg[i] <= 1'b0;
      end else if (cdb_hit[i]) begin
        ready_reg[i] <= 1'b1;
        value_reg[i] <= bus.cdb_value;
      end
    end
  end

  assign bus.alloc_addr  = tail_reg;
  assign bus.full        = full;
  assign bus.empty       = empty;
  assign bus.rob_addr    = head_reg;
  assign bus.valid_out   = head_valid;
  assign bus.opcode_out  = opcode_reg[head_reg];
  assign bus.dest_out    = dest_reg[head_reg];
  assign bus.value_out   = value_reg[head_reg];
  assign bus.predict_out = predict_reg[head_reg];

  // The lookup ports forward the live CDB value. A dispatching instruction
  // can then capture a result that is broadcast in the same cycle.
  logic bypass_a;
  logic bypass_b;

  assign bypass_a       = bus.cdb_valid && (bus.cdb_tag == bus.rd_tag_a);
  assign bypass_b       = bus.cdb_valid && (bus.cdb_tag == bus.rd_tag_b);
  assign bus.rd_valid_a = alloc_reg[bus.rd_tag_a] && (ready_reg[bus.rd_tag_a] || bypass_a);
  assign bus.rd_valid_b = alloc_reg[bus.rd_tag_b] && (ready_reg[bus.rd_tag_b] || bypass_b);
  assign bus.rd_value_a = bypass_a ? bus.cdb_value : value_reg[bus.rd_tag_a];
  assign bus.rd_value_b = bypass_b ? bus.cdb_value : value_reg[bus.rd_tag_b];
endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer. A queue of in-flight
// instructions in program order serves as the reference. The bench checks
// every output against it at each falling edge. Directed steps also check
// literal values worked out by hand.
module tb_reorder_buffer;
  logic clk = 1'b0;
  logic clr;
  logic flush;

  always #5 clk = ~clk;

  reorder_buffer_if #(.data_width(16), .tag_width(3)) rob_bus ();

  reorder_buffer #(.data_width(16), .tag_width(3)) dut (
    .clk  (clk),
    .clr  (clr),
    .flush(flush),
    .bus  (rob_bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference: the in-flight instructions in program order, oldest first.
  typedef struct {
    logic [2:0]  tag;
    logic [3:0]  op;
    logic [2:0]  dest;
    logic        pred;
    logic        rdy;
    logic [15:0] val;
  } ent_t;

  ent_t       q[$];
  logic [2:0] next_tag;
  bit         live = 0;

  function automatic int find(input logic [2:0] t);
    foreach (q[k]) if (q[k].tag == t) return k;
    return -1;
  endfunction

  always @(posedge clk) begin
    bit   was_full;
    bit   was_valid;
    ent_t e;
    if (clr) begin
      q.delete();
      next_tag = 3'd0;
      live = 1;
    end else if (flush) begin
      q.delete();
      next_tag = 3'd0;
    end else begin
      was_full  = (q.size() == 8);
      was_valid = (q.size() > 0) && q[0].rdy;
      if (rob_bus.cdb_valid)
        foreach (q[k])
          if (q[k].tag == rob_bus.cdb_tag) begin
            q[k].rdy = 1'b1;
            q[k].val = rob_bus.cdb_value;
          end
      if (rob_bus.RE && was_valid) void'(q.pop_front());
      if (rob_bus.WE && !was_full) begin
        e.tag  = next_tag;
        e.op   = rob_bus.inst_opcode;
        e.dest = rob_bus.inst_dest;
        e.pred = rob_bus.inst_predict;
        e.rdy  = 1'b0;
        e.val  = 16'h0;
        q.push_back(e);
        next_tag = next_tag + 3'd1;
      end
    end
  end

  always @(negedge clk) begin
    int         ia;
    int         ib;
    logic [2:0] head_tag;
    bit         byp;
    if (live) begin
      head_tag = (q.size() > 0) ? q[0].tag : next_tag;
      chk("empty", 32'(rob_bus.empty), 32'(q.size() == 0));
      chk("full", 32'(rob_bus.full), 32'(q.size() == 8));
      chk("alloc_addr", 32'(rob_bus.alloc_addr), 32'(next_tag));
      chk("rob_addr", 32'(rob_bus.rob_addr), 32'(head_tag));
      chk("valid_out", 32'(rob_bus.valid_out), 32'((q.size() > 0) && q[0].rdy));
      if (q.size() > 0) begin
        chk("opcode_out", 32'(rob_bus.opcode_out), 32'(q[0].op));
        chk("dest_out", 32'(rob_bus.dest_out), 32'(q[0].dest));
        chk("predict_out", 32'(rob_bus.predict_out), 32'(q[0].pred));
        chk("value_out", 32'(rob_bus.value_out), 32'(q[0].val));
      end
      ia = find(rob_bus.rd_tag_a);
      byp = rob_bus.cdb_valid && (rob_bus.cdb_tag == rob_bus.rd_tag_a);
      chk("rd_valid_a", 32'(rob_bus.rd_valid_a), 32'((ia >= 0) && (byp || q[ia].rdy)));
      if (ia >= 0)
        chk("rd_value_a", 32'(rob_bus.rd_value_a), 32'(byp ? rob_bus.cdb_value : q[ia].val));
      ib = find(rob_bus.rd_tag_b);
      byp = rob_bus.cdb_valid && (rob_bus.cdb_tag == rob_bus.rd_tag_b);
      chk("rd_valid_b", 32'(rob_bus.rd_valid_b), 32'((ib >= 0) && (byp || q[ib].rdy)));
      if (ib >= 0)
        chk("rd_value_b", 32'(rob_bus.rd_value_b), 32'(byp ? rob_bus.cdb_value : q[ib].val));
    end
  end

  // One clock with the given requests. The pulse inputs are idle again
  // after the edge.
  task automatic cyc(input bit we, input logic [3:0] op, input logic [2:0] dst, input bit pr,
                     input bit cv, input logic [2:0] ct, input logic [15:0] cval,
                     input bit re, input bit fl);
    rob_bus.WE = we;
    rob_bus.inst_opcode = op;
    rob_bus.inst_dest = dst;
    rob_bus.inst_predict = pr;
    rob_bus.cdb_valid = cv;
    rob_bus.cdb_tag = ct;
    rob_bus.cdb_value = cval;
    rob_bus.RE = re;
    flush = fl;
    @(posedge clk);
    #1;
    rob_bus.WE = 1'b0;
    rob_bus.cdb_valid = 1'b0;
    rob_bus.RE = 1'b0;
    flush = 1'b0;
  endtask

  task automatic alloc(input logic [3:0] op, input logic [2:0] dst, input bit pr);
    cyc(1, op, dst, pr, 0, 3'd0, 16'h0, 0, 0);
  endtask

  task automatic cdb(input logic [2:0] t, input logic [15:0] v, input bit re);
    cyc(0, 4'h0, 3'd0, 0, 1, t, v, re, 0);
  endtask

  task automatic retire();
    cyc(0, 4'h0, 3'd0, 0, 0, 3'd0, 16'h0, 1, 0);
  endtask

  task automatic do_reset();
    clr = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    clr = 1'b0;
  endtask

  initial begin
    rob_bus.WE = 0; rob_bus.inst_opcode = 0; rob_bus.inst_dest = 0; rob_bus.inst_predict = 0;
    rob_bus.cdb_valid = 0; rob_bus.cdb_tag = 0; rob_bus.cdb_value = 0; rob_bus.RE = 0;
    rob_bus.rd_tag_a = 0; rob_bus.rd_tag_b = 0; flush = 0;

    // Reset values
    do_reset();
    chk("rst empty", 32'(rob_bus.empty), 32'd1);
    chk("rst full", 32'(rob_bus.full), 32'd0);
    chk("rst valid_out", 32'(rob_bus.valid_out), 32'd0);
    chk("rst alloc_addr", 32'(rob_bus.alloc_addr), 32'd0);
    chk("rst rob_addr", 32'(rob_bus.rob_addr), 32'd0);
    chk("rst opcode_out", 32'(rob_bus.opcode_out), 32'd0);
    chk("rst dest_out", 32'(rob_bus.dest_out), 32'd0);
    chk("rst value_out", 32'(rob_bus.value_out), 32'd0);
    chk("rst predict_out", 32'(rob_bus.predict_out), 32'd0);
    chk("rst rd_valid_a", 32'(rob_bus.rd_valid_a), 32'd0);
    chk("rst rd_value_a", 32'(rob_bus.rd_value_a), 32'd0);
    $display("txn reset done");

    // Allocate three entries, then the CDB fills tag 0
    alloc(4'h1, 3'd1, 0);
    alloc(4'h6, 3'd2, 0);
    alloc(4'h0, 3'd0, 1);
    chk("three alloc_addr", 32'(rob_bus.alloc_addr), 32'd3);
    chk("three empty", 32'(rob_bus.empty), 32'd0);
    chk("three valid_out", 32'(rob_bus.valid_out), 32'd0);
    cdb(3'd0, 16'h1234, 0);
    chk("cdb0 valid_out", 32'(rob_bus.valid_out), 32'd1);
    chk("cdb0 value_out", 32'(rob_bus.value_out), 32'h1234);
    chk("cdb0 dest_out", 32'(rob_bus.dest_out), 32'd1);
    cdb(3'd1, 16'h1111, 1);
    cdb(3'd2, 16'h2222, 1);
    retire();
    chk("three drained", 32'(rob_bus.empty), 32'd1);
    $display("txn three allocs retired, rob_addr=%0d", rob_bus.rob_addr);

    // Fill to full; WE while full is ignored even with RE in the same cycle
    do_reset();
    for (int i = 0; i < 8; i++) alloc(4'(i + 1), 3'(i), 1'(i));
    chk("fill full", 32'(rob_bus.full), 32'd1);
    chk("fill alloc_addr", 32'(rob_bus.alloc_addr), 32'd0);
    alloc(4'hF, 3'd7, 1);
    chk("ninth alloc_addr", 32'(rob_bus.alloc_addr), 32'd0);
    chk("ninth full", 32'(rob_bus.full), 32'd1);
    cdb(3'd0, 16'hA000, 0);
    cyc(1, 4'hF, 3'd7, 1, 0, 3'd0, 16'h0, 1, 0);
    chk("we+re full", 32'(rob_bus.full), 32'd0);
    chk("we+re rob_addr", 32'(rob_bus.rob_addr), 32'd1);
    chk("we+re alloc_addr", 32'(rob_bus.alloc_addr), 32'd0);
    alloc(4'hE, 3'd6, 0);
    chk("refill full", 32'(rob_bus.full), 32'd1);
    chk("refill alloc_addr", 32'(rob_bus.alloc_addr), 32'd1);
    $display("txn fill/full done");

    // Steady stream through the pointer wrap. Entry k holds 0x100+k.
    do_reset();
    for (int i = 0; i < 20; i++)
      cyc(1, 4'(i), 3'(i), 1'(i), i > 0, 3'(i - 1), 16'(16'h100 + i - 1), 1, 0);
    chk("wrap rob_addr", 32'(rob_bus.rob_addr), 32'd2);
    chk("wrap alloc_addr", 32'(rob_bus.alloc_addr), 32'd4);
    chk("wrap valid_out", 32'(rob_bus.valid_out), 32'd1);
    chk("wrap value_out", 32'(rob_bus.value_out), 32'h0112);
    cdb(3'd3, 16'h0113, 1);
    retire();
    chk("wrap drained", 32'(rob_bus.empty), 32'd1);
    $display("txn wrap stream done");

    // Results arrive out of order; a broadcast to unallocated tag 5 is dropped
    do_reset();
    rob_bus.rd_tag_b = 3'd5;
    for (int i = 0; i < 3; i++) alloc(4'(i + 2), 3'(i + 3), 0);
    cdb(3'd2, 16'h0C02, 1);
    chk("ooo2 rob_addr", 32'(rob_bus.rob_addr), 32'd0);
    chk("ooo2 valid_out", 32'(rob_bus.valid_out), 32'd0);
    cdb(3'd1, 16'h0C01, 1);
    chk("ooo1 rob_addr", 32'(rob_bus.rob_addr), 32'd0);
    cdb(3'd5, 16'hDEAD, 1);
    chk("ooo5 valid_out", 32'(rob_bus.valid_out), 32'd0);
    chk("ooo5 alloc_addr", 32'(rob_bus.alloc_addr), 32'd3);
    chk("ooo5 rd_valid_b", 32'(rob_bus.rd_valid_b), 32'd0);
    cdb(3'd0, 16'h0C00, 0);
    chk("ooo0 value_out", 32'(rob_bus.value_out), 32'h0C00);
    retire();
    chk("ooo r1 value_out", 32'(rob_bus.value_out), 32'h0C01);
    retire();
    chk("ooo r2 rob_addr", 32'(rob_bus.rob_addr), 32'd2);
    retire();
    chk("ooo r3 empty", 32'(rob_bus.empty), 32'd1);
    chk("ooo r3 rob_addr", 32'(rob_bus.rob_addr), 32'd3);
    $display("txn out-of-order done");

    // Flush with WE, RE and CDB in the same cycle
    do_reset();
    rob_bus.rd_tag_a = 3'd1;
    for (int i = 0; i < 5; i++) alloc(4'(i), 3'(i), 0);
    cdb(3'd0, 16'h5000, 0);
    cyc(1, 4'h9, 3'd5, 1, 1, 3'd1, 16'h5001, 1, 1);
    chk("flush empty", 32'(rob_bus.empty), 32'd1);
    chk("flush alloc_addr", 32'(rob_bus.alloc_addr), 32'd0);
    chk("flush rob_addr", 32'(rob_bus.rob_addr), 32'd0);
    chk("flush valid_out", 32'(rob_bus.valid_out), 32'd0);
    chk("flush full", 32'(rob_bus.full), 32'd0);
    cdb(3'd1, 16'hBEEF, 0);
    chk("post-flush empty", 32'(rob_bus.empty), 32'd1);
    chk("post-flush rd_valid_a", 32'(rob_bus.rd_valid_a), 32'd0);
    $display("txn flush done");

    // Lookup port sees the same-cycle broadcast
    for (int i = 0; i < 3; i++) alloc(4'(i + 7), 3'(i), 0);
    rob_bus.rd_tag_a = 3'd1;
    rob_bus.rd_tag_b = 3'd2;
    rob_bus.cdb_valid = 1'b1;
    rob_bus.cdb_tag = 3'd1;
    rob_bus.cdb_value = 16'h00FF;
    #1;
    chk("bypass rd_valid_a", 32'(rob_bus.rd_valid_a), 32'd1);
    chk("bypass rd_value_a", 32'(rob_bus.rd_value_a), 32'h00FF);
    chk("bypass rd_valid_b", 32'(rob_bus.rd_valid_b), 32'd0);
    @(posedge clk);
    #1;
    rob_bus.cdb_valid = 1'b0;
    #1;
    chk("stored rd_valid_a", 32'(rob_bus.rd_valid_a), 32'd1);
    chk("stored rd_value_a", 32'(rob_bus.rd_value_a), 32'h00FF);
    chk("stored rd_valid_b", 32'(rob_bus.rd_valid_b), 32'd0);
    $display("txn read-port bypass done");

    repeat (3) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
